// File: rtl/mem_access_ctrl.sv
// Request sequencer for the 8-word bitcell array: drives decoder address/select and array write
// enable in a setup/strobe/hold sequence and returns read data through a response handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a request; select and we low
// S_SETUP  | address held stable, select low, SETUP_CYC cycles
// S_STROBE | select high (we high for writes), PULSE_CYC cycles
// S_HOLD   | one cycle, select/we low, address still held; wr_done on writes
// S_RESP   | read data presented until the consumer takes it
module mem_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_wr_done,
  output logic              o_dec_select,
  output logic              o_dec_adr0,
  output logic              o_dec_adr1,
  output logic              o_dec_adr2,
  output logic              o_array_we,
  output logic [DATA_W-1:0] o_array_wdata,
  input  logic [DATA_W-1:0] i_array_rdata
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic                r_op_we;
  logic [2:0]          r_adr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_req_ready;
  logic                r_select;
  logic                r_we;
  logic                r_wr_done;
  logic                r_rsp_valid;
  logic                w_accept;
  logic                w_capture;

  assign w_accept  = (r_state == S_IDLE) && i_req_valid;
  assign w_capture = (r_state == S_STROBE) && (r_cnt == '0) && !r_op_we;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state = S_SETUP;
          w_nxt_cnt   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_STROBE;
          w_nxt_cnt   = PULSE_LD;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_HOLD;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        w_nxt_state = r_op_we ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_nxt_state = S_IDLE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch cleanly with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_we     <= 1'b0;
      r_adr       <= 3'b000;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_req_ready <= 1'b1;
      r_select    <= 1'b0;
      r_we        <= 1'b0;
      r_wr_done   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_req_ready <= (w_nxt_state == S_IDLE);
      r_select    <= (w_nxt_state == S_STROBE);
      r_we        <= (w_nxt_state == S_STROBE) && r_op_we;
      r_wr_done   <= (w_nxt_state == S_HOLD) && r_op_we;
      r_rsp_valid <= (w_nxt_state == S_RESP);
      if (w_accept) begin
        r_op_we <= i_req_we;
        r_adr   <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      if (w_capture) begin
        r_rdata <= i_array_rdata;
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rdata;
  assign o_wr_done     = r_wr_done;
  assign o_dec_select  = r_select;
  assign o_dec_adr0    = r_adr[0];
  assign o_dec_adr1    = r_adr[1];
  assign o_dec_adr2    = r_adr[2];
  assign o_array_we    = r_we;
  assign o_array_wdata = r_wdata;

endmodule
